// File: rtl/iir_coeff_ctrl.sv
// ============================================================================
// Module      : iir_coeff_ctrl
// Description : Coefficient configuration controller for the IIR filter
//               stages. Coefficient writes land in a shadow bank over a
//               valid/ready handshake; a commit swaps the shadow bank into
//               the active bank atomically on the next filter sample strobe,
//               after which the filter delay lines are flushed.
//               Optional feature macro: IIR_COEFF_READBACK_EN adds a
//               registered shadow-bank readback port (rd_addr / rd_data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_coeff_ctrl #(
    parameter int N            = 4,
    parameter int COEFF_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 3,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [COEFF_WIDTH-1:0]     wr_data,
    input  logic                       commit,
    input  logic                       sample_en,
    output logic                       busy,
    output logic                       addr_err,
    output logic                       filter_flush,
`ifdef IIR_COEFF_READBACK_EN
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic [COEFF_WIDTH-1:0]     rd_data,
`endif
    output logic [COEFF_WIDTH*N-1:0]   packed_b_coeffs,
    output logic [COEFF_WIDTH*N-1:0]   packed_a_coeffs
);

    localparam int                  c_DEPTH   = 2 * N;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_A = (ADDR_WIDTH + 1)'(2 * N);
    localparam int                  c_CNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST    = c_CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_wr_ready;
    logic                    r_busy;
    logic                    r_flush;
    logic                    r_addr_err;

    logic [COEFF_WIDTH-1:0]  r_shadow   [c_DEPTH];
    logic [COEFF_WIDTH-1:0]  r_active_b [N];
    logic [COEFF_WIDTH-1:0]  r_active_a [N];

    logic                    w_wr_fire;
    logic                    w_addr_ok;
    logic                    w_swap;

    // r_wr_ready is high exactly when the FSM sits in IDLE, so it gates writes.
    assign w_wr_fire = wr_valid && r_wr_ready;
    assign w_addr_ok = ({1'b0, wr_addr} < c_DEPTH_A);
    assign w_swap    = (r_state == S_PEND) && sample_en;

    // Control FSM: IDLE accepts writes, PEND waits for a sample strobe, FLUSH holds the delay lines.
    // A commit clears addr_err even if the same cycle carries an out-of-range write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_flush    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_fire && !w_addr_ok) begin
                        r_addr_err <= 1'b1;
                    end
                    if (commit) begin
                        r_addr_err <= 1'b0;
                        r_state    <= S_PEND;
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_PEND: begin
                    if (sample_en) begin
                        if (FLUSH_CYCLES == 0) begin
                            r_state    <= S_IDLE;
                            r_wr_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state <= S_FLUSH;
                            r_flush <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == c_LAST) begin
                        r_state    <= S_IDLE;
                        r_flush    <= 1'b0;
                        r_wr_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_wr_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_flush    <= 1'b0;
                end
            endcase
        end
    end

    // Shadow bank: an accepted in-range write updates its entry; out-of-range data never matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (w_wr_fire && (wr_addr == ADDR_WIDTH'(i))) begin
                    r_shadow[i] <= wr_data;
                end
            end
        end
    end

    // Active bank: the whole shadow bank is copied in one edge so no partial set is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < N; t++) begin
                r_active_b[t] <= '0;
                r_active_a[t] <= '0;
            end
        end else if (w_swap) begin
            for (int t = 0; t < N; t++) begin
                r_active_b[t] <= r_shadow[t];
                r_active_a[t] <= r_shadow[N + t];
            end
        end
    end

    for (genvar gt = 0; gt < N; gt++) begin : g_pack
        assign packed_b_coeffs[COEFF_WIDTH*gt +: COEFF_WIDTH] = r_active_b[gt];
        assign packed_a_coeffs[COEFF_WIDTH*gt +: COEFF_WIDTH] = r_active_a[gt];
    end

    assign wr_ready     = r_wr_ready;
    assign busy         = r_busy;
    assign filter_flush = r_flush;
    assign addr_err     = r_addr_err;

`ifdef IIR_COEFF_READBACK_EN
    logic [COEFF_WIDTH-1:0] w_rd_mux;
    logic [COEFF_WIDTH-1:0] r_rd_data;

    // Readback mux: out-of-range addresses match no entry and return zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                w_rd_mux = r_shadow[i];
            end
        end
    end

    // Readback register: one cycle of latency from rd_addr to rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data = r_rd_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iir_coeff_ctrl.sv
// ============================================================================
// Module      : tb_iir_coeff_ctrl
// Description : Self-checking bench for iir_coeff_ctrl. A main instance
//               (N=4, FLUSH_CYCLES=4) is compared every cycle against a
//               behavioural model; a second instance (N=3, FLUSH_CYCLES=0)
//               covers out-of-range addresses and the zero-flush case.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iir_coeff_ctrl;

    localparam int N   = 4;
    localparam int CW  = 16;
    localparam int AW  = 3;
    localparam int FC  = 4;
    localparam int N1  = 3;

    localparam int M_IDLE  = 0;
    localparam int M_PEND  = 1;
    localparam int M_FLUSH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic          wr_valid  = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [CW-1:0] wr_data   = '0;
    logic          commit    = 1'b0;
    logic          sample_en = 1'b0;
    logic          wr_ready, busy, addr_err, filter_flush;
    logic [CW*N-1:0] pb, pa;
    logic [AW-1:0] rd_addr   = '0;
    logic [CW-1:0] rd_data;

    // Second instance signals
    logic          u1_valid  = 1'b0;
    logic [AW-1:0] u1_addr   = '0;
    logic [CW-1:0] u1_data   = '0;
    logic          u1_commit = 1'b0;
    logic          u1_sample = 1'b0;
    logic          u1_ready, u1_busy, u1_err, u1_flush;
    logic [CW*N1-1:0] u1_pb, u1_pa;
    logic [CW-1:0] u1_rd_data;

    iir_coeff_ctrl #(.N(N), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW), .FLUSH_CYCLES(FC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .commit          (commit),
        .sample_en       (sample_en),
        .busy            (busy),
        .addr_err        (addr_err),
        .filter_flush    (filter_flush),
`ifdef IIR_COEFF_READBACK_EN
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
`endif
        .packed_b_coeffs (pb),
        .packed_a_coeffs (pa)
    );

    iir_coeff_ctrl #(.N(N1), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW), .FLUSH_CYCLES(0)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_valid        (u1_valid),
        .wr_ready        (u1_ready),
        .wr_addr         (u1_addr),
        .wr_data         (u1_data),
        .commit          (u1_commit),
        .sample_en       (u1_sample),
        .busy            (u1_busy),
        .addr_err        (u1_err),
        .filter_flush    (u1_flush),
`ifdef IIR_COEFF_READBACK_EN
        .rd_addr         (rd_addr),
        .rd_data         (u1_rd_data),
`endif
        .packed_b_coeffs (u1_pb),
        .packed_a_coeffs (u1_pa)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model of the main instance
    // ------------------------------------------------------------------
    int            m_mode;
    int            m_left;
    logic          m_err;
    logic [CW-1:0] m_sh [2*N];
    logic [CW-1:0] m_b  [N];
    logic [CW-1:0] m_a  [N];
    logic [CW-1:0] m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_left = 0;
            m_err  = 1'b0;
            m_rd   = '0;
            for (int i = 0; i < 2*N; i++) m_sh[i] = '0;
            for (int t = 0; t < N; t++) begin
                m_b[t] = '0;
                m_a[t] = '0;
            end
        end else begin
            m_rd = (int'(rd_addr) < 2*N) ? m_sh[rd_addr] : '0;
            case (m_mode)
                M_IDLE: begin
                    if (wr_valid) begin
                        if (int'(wr_addr) < 2*N) m_sh[wr_addr] = wr_data;
                        else                     m_err = 1'b1;
                    end
                    if (commit) begin
                        m_err  = 1'b0;
                        m_mode = M_PEND;
                    end
                end
                M_PEND: begin
                    if (sample_en) begin
                        for (int t = 0; t < N; t++) begin
                            m_b[t] = m_sh[t];
                            m_a[t] = m_sh[N + t];
                        end
                        if (FC == 0) begin
                            m_mode = M_IDLE;
                        end else begin
                            m_mode = M_FLUSH;
                            m_left = FC;
                        end
                    end
                end
                default: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            endcase
        end
    end

    // Per-cycle comparison of every main-instance output against the model
    always @(negedge clk) begin
        logic [CW*N-1:0] eb, ea;
        for (int t = 0; t < N; t++) begin
            eb[CW*t +: CW] = m_b[t];
            ea[CW*t +: CW] = m_a[t];
        end
        chk("wr_ready",     64'(wr_ready),     64'(m_mode == M_IDLE));
        chk("busy",         64'(busy),         64'(m_mode != M_IDLE));
        chk("filter_flush", 64'(filter_flush), 64'(m_mode == M_FLUSH));
        chk("addr_err",     64'(addr_err),     64'(m_err));
        chk("packed_b",     64'(pb),           64'(eb));
        chk("packed_a",     64'(pa),           64'(ea));
`ifdef IIR_COEFF_READBACK_EN
        chk("rd_data",      64'(rd_data),      64'(m_rd));
`endif
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after the rising edge
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [AW-1:0] a, input logic [CW-1:0] d,
                        input logic c, input logic s);
        wr_valid  = v;
        wr_addr   = a;
        wr_data   = d;
        commit    = c;
        sample_en = s;
        rd_addr   = AW'($urandom);
        cyc();
    endtask

    task automatic step1(input logic v, input logic [AW-1:0] a, input logic [CW-1:0] d,
                         input logic c, input logic s);
        u1_valid  = v;
        u1_addr   = a;
        u1_data   = d;
        u1_commit = c;
        u1_sample = s;
        cyc();
    endtask

    logic [CW-1:0] ld [8];

    initial begin
        ld = '{16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h4000, 16'hE000, 16'h0000, 16'h0000};

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_pb",    64'(pb), 64'h0);
        chk("rst_pa",    64'(pa), 64'h0);
        chk("rst_ready", 64'(wr_ready), 64'h1);
        chk("rst_busy",  64'(busy), 64'h0);
        chk("rst_flush", 64'(filter_flush), 64'h0);
        chk("rst_err",   64'(addr_err), 64'h0);

        // Load and swap
        for (int i = 0; i < 8; i++) step(1'b1, AW'(i), ld[i], 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("commit_busy",  64'(busy), 64'h1);
        chk("commit_ready", 64'(wr_ready), 64'h0);
        repeat (4) step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("pend_pb_old", 64'(pb), 64'h0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("swap_pb", 64'(pb), 64'h0200_0400_0800_1000);
        chk("swap_pa", 64'(pa), 64'h0000_0000_E000_4000);
        chk("flush_1", 64'(filter_flush), 64'h1);
        for (int k = 2; k <= 4; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0);
            chk("flush_held", 64'(filter_flush), 64'h1);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("flush_end", 64'(filter_flush), 64'h0);
        chk("idle_ready", 64'(wr_ready), 64'h1);

        // Atomicity: writes during PEND are refused and outputs hold
        step(1'b0, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, AW'($urandom), CW'($urandom), 1'b0, 1'b0);
            chk("atom_ready", 64'(wr_ready), 64'h0);
            chk("atom_pb",    64'(pb), 64'h0200_0400_0800_1000);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("atom_swap_pb", 64'(pb), 64'h0200_0400_0800_1000);
        chk("atom_swap_pa", 64'(pa), 64'h0000_0000_E000_4000);
        repeat (4) step(1'b0, '0, '0, 1'b0, 1'b0);

        // Same-cycle write and commit
        step(1'b1, 3'd0, 16'h7FFF, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("wc_pb", 64'(pb), 64'h0200_0400_0800_7FFF);
        repeat (4) step(1'b0, '0, '0, 1'b0, 1'b0);

        // Out-of-range addresses and zero flush cycles on the N=3 instance
        step1(1'b1, 3'd1, 16'h0011, 1'b0, 1'b0);
        step1(1'b1, 3'd7, 16'hFFFF, 1'b0, 1'b0);
        chk("u1_err_set",   64'(u1_err), 64'h1);
        chk("u1_err_ready", 64'(u1_ready), 64'h1);
        step1(1'b1, 3'd6, 16'hEEEE, 1'b0, 1'b0);
        chk("u1_err_hold",  64'(u1_err), 64'h1);
        step1(1'b0, '0, '0, 1'b1, 1'b0);
        chk("u1_err_clr",   64'(u1_err), 64'h0);
        chk("u1_busy",      64'(u1_busy), 64'h1);
        step1(1'b0, '0, '0, 1'b0, 1'b1);
        chk("u1_ready",     64'(u1_ready), 64'h1);
        chk("u1_nobusy",    64'(u1_busy), 64'h0);
        chk("u1_noflush",   64'(u1_flush), 64'h0);
        chk("u1_pb",        64'(u1_pb), 64'h0000_0011_0000);
        chk("u1_pa",        64'(u1_pa), 64'h0);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom), AW'($urandom), CW'($urandom),
                 ($urandom % 16) == 0, ($urandom % 4) == 0);
        end

        // Drain to IDLE, then reset during the second flush cycle
        repeat (8) step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 3'd2, 16'h5A5A, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("mid_flush_on", 64'(filter_flush), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flush", 64'(filter_flush), 64'h0);
        chk("mid_rst_pb",    64'(pb), 64'h0);
        chk("mid_rst_pa",    64'(pa), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid_rel_ready", 64'(wr_ready), 64'h1);
        chk("mid_rel_busy",  64'(busy), 64'h0);
        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iir_coeff_ctrl.md
# iir_coeff_ctrl

Coefficient configuration controller for the analogue-path IIR filter stages. It accepts coefficient writes over a valid/ready handshake into a shadow bank and swaps the shadow bank into the active bank atomically on a filter sample strobe. After the swap it asserts a flush so the filter delay lines never mix old-coefficient history with new coefficients. It drives the packed b (feed-forward) and a (feedback) coefficient buses of the filter stages.

## Interface
- N, 4, taps per coefficient set (b and a each hold N coefficients)
- COEFF_WIDTH, 16, signed coefficient width
- ADDR_WIDTH, 3, write address width; must satisfy 2^ADDR_WIDTH >= 2*N
- FLUSH_CYCLES, 4, cycles filter_flush is held after a swap; 0 is legal

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  coefficient write request
- wr_ready  out  1  controller can accept a write
- wr_addr  in  ADDR_WIDTH  0..N-1 selects b[addr]; N..2N-1 selects a[addr-N]
- wr_data  in  COEFF_WIDTH  coefficient value
- commit  in  1  single-cycle request to swap shadow into active
- sample_en  in  1  filter sample strobe; a swap occurs only on this strobe
- busy  out  1  commit pending or flush in progress
- addr_err  out  1  sticky: a write with wr_addr >= 2N was accepted
- filter_flush  out  1  hold/clear for the filter delay lines
- packed_b_coeffs  out  COEFF_WIDTH*N  active b bank; b[t] occupies bits [COEFF_WIDTH*t +: COEFF_WIDTH]
- packed_a_coeffs  out  COEFF_WIDTH*N  active a bank, same packing as b

## Operation
- Reset values: state IDLE, shadow and active banks all zero, packed outputs 0, wr_ready=1, busy=0, addr_err=0, filter_flush=0, flush counter 0.
- States:
  - IDLE: wr_ready=1. A write transfer (wr_valid && wr_ready) updates the selected shadow entry on that edge. commit moves the block to PEND.
  - PEND: wr_ready=0, busy=1. commit is ignored. On the first cycle with sample_en=1, active is loaded from shadow on that edge and the block moves to FLUSH, or to IDLE if FLUSH_CYCLES=0.
  - FLUSH: wr_ready=0, busy=1, filter_flush=1. The counter runs FLUSH_CYCLES cycles, then the block returns to IDLE.
- wr_valid && commit in the same IDLE cycle: the write lands in the shadow bank first and is included in the pending swap.
- Out-of-range address (>= 2N): the handshake completes, the data is discarded and addr_err is set. addr_err clears on the edge that accepts a commit.
- sample_en outside PEND has no effect. The shadow bank persists across swaps, so a partial rewrite followed by commit is legal.
- Active banks change only at the swap edge. No partial update is ever visible on packed_b_coeffs or packed_a_coeffs.
- rst_n asserted in any state restores all reset values immediately, including any mid-flush state. Shadow contents are lost.

## Timing
- Write: one transfer per cycle while in IDLE. The shadow entry is updated at the accepting edge.
- commit sampled high at edge k in IDLE: busy=1 and wr_ready=0 from cycle k+1.
- sample_en high at edge s in PEND: new coefficients appear on the packed outputs in cycle s+1. filter_flush is high during cycles s+1 .. s+FLUSH_CYCLES. IDLE and wr_ready=1 resume at cycle s+FLUSH_CYCLES+1.
- FLUSH_CYCLES=0: IDLE resumes at cycle s+1 and filter_flush never asserts.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Configuration
- IIR_COEFF_READBACK_EN defined:
  - Adds input rd_addr [ADDR_WIDTH] and output rd_data [COEFF_WIDTH].
  - rd_data returns the shadow entry at rd_addr one cycle after the address is presented.
  - An out-of-range rd_addr returns 0.
  - Reset value of rd_data is 0.
- Undefined: the ports and the readback logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset check: assert rst_n=0, release -> both packed buses 0, wr_ready=1, busy=0, filter_flush=0, addr_err=0.
- Load and swap: write b[0..3]=16'h1000,16'h0800,16'h0400,16'h0200 and a[0..3]=16'h4000,16'hE000,0,0; commit; sample_en 5 cycles later -> packed_b_coeffs=64'h0200_0400_0800_1000 and packed_a_coeffs=64'h0000_0000_E000_4000 from the next cycle; filter_flush high exactly 4 cycles; then wr_ready=1.
- Atomicity: issue commit, then hold sample_en=0 for 20 cycles while driving wr_valid -> wr_ready=0 throughout, packed outputs unchanged, shadow unchanged.
- Same-cycle write+commit: wr_addr=0, wr_data=16'h7FFF with commit in one cycle -> after swap, b[0]=16'h7FFF.
- Address error: write wr_addr=7 with N=3 -> handshake completes, addr_err=1, banks unchanged; next commit clears addr_err.
- Reset mid-flush: assert rst_n=0 during the 2nd flush cycle -> filter_flush=0, packed outputs 0, state IDLE on release.
